hs_collect_sync: RTL and testbench

Clocked sink that terminates the four request/acknowledge output channels (a, b, c, d) of the `join_fork_big` handshake network and hands their data to the synchronous domain. Each channel's request is synchronised and its bundled data bit captured, and the channel is acknowledged with a four-phase handshake. Once all four channels hold a token, the tokens are joined into one 4-bit word and pushed into a small FIFO, which is drained through a valid/ready port. The block is the downstream stage of the handshake network and the boundary into clocked logic.

---
 rtl/hs_collect_sync.sv | 157 +++++++++++++++
 tb/tb_hs_collect_sync.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_collect_sync.sv
// hs_collect_sync
//   Clocked sink for four bundled-data four-phase channels (a, b, c, d).
//   Each request is synchronised and its data bit is captured into a one-bit
//   slot. The channel is then acknowledged. When all four slots are full, the
//   slots are joined into {d,c,b,a} and pushed into a small word FIFO. The
//   FIFO drains through a valid/ready port.
//
// Ports
//   clk, rst          : clock; asynchronous active-high reset
//   a, b, c, d        : bundled data bit per channel (stable while rr_* high)
//   rr_a .. rr_d      : channel request, asynchronous four-phase level
//   ra_a .. ra_d      : channel acknowledge (registered)
//   o_data            : FIFO head word {d,c,b,a}; holds last value when empty
//   o_valid           : FIFO non-empty
//   o_ready           : consumer takes o_data on this edge
//   o_count           : FIFO occupancy
//
// Handshake on the output port: a word transfers on a rising edge where
// o_valid and o_ready are both high. o_data/o_valid change only after such
// a transfer or after a push, and never depend combinationally on o_ready.
module hs_collect_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          a,
  input  logic                          b,
  input  logic                          c,
  input  logic                          d,
  input  logic                          rr_a,
  input  logic                          rr_b,
  input  logic                          rr_c,
  input  logic                          rr_d,
  output logic                          ra_a,
  output logic                          ra_b,
  output logic                          ra_c,
  output logic                          ra_d,
  output logic [3:0]                    o_data,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  // Channel index 0..3 = a..d, so a bit-vector of channels is already {d,c,b,a}.
  logic [3:0] rr_raw;
  logic [3:0] din;
  assign rr_raw = {rr_d, rr_c, rr_b, rr_a};
  assign din    = {d, c, b, a};

  // Request synchronisers
  logic [SYNC_STAGES-1:0] sync_q [4];
  logic [3:0]             rr_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], rr_raw[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) rr_s[i] = sync_q[i][SYNC_STAGES-1];
  end

  // Channel slots and FIFO state
  logic [3:0]  ack_q, ack_d;
  logic [3:0]  slot_q, slot_d;
  logic [3:0]  tok_q, tok_d;
  logic [3:0]  data_q, data_d;
  logic [AW:0] wr_q, rd_q;
  logic [3:0]  mem_q [FIFO_DEPTH];

  logic [AW:0]   count;
  logic [AW-1:0] rd_nxt;
  logic          valid;
  logic          full;
  logic          pop;
  logic          push;

  assign count  = wr_q - rd_q;
  assign valid  = (count != '0);
  assign full   = (count == CNT_FULL);
  assign pop    = valid & o_ready;
  // A pop on the same edge frees the slot the push needs.
  assign push   = (&slot_q) & (~full | pop);
  assign rd_nxt = rd_q[AW-1:0] + AW'(1);

  always_comb begin
    ack_d  = ack_q;
    slot_d = slot_q;
    tok_d  = tok_q;
    data_d = data_q;

    for (int i = 0; i < 4; i++) begin
      // A new token waits for both the previous handshake to finish and the
      // previous word to leave the slot.
      if (rr_s[i] && !ack_q[i] && !slot_q[i]) begin
        tok_d[i]  = din[i];
        slot_d[i] = 1'b1;
        ack_d[i]  = 1'b1;
      end else if (ack_q[i] && !rr_s[i]) begin
        ack_d[i] = 1'b0;
      end
    end

    // A push needs every slot full, so it never overlaps a capture.
    if (push) slot_d = '0;

    // Registered head word: advance on pop, load directly when the FIFO is
    // (or is about to become) empty and a word is pushed, else hold.
    if (pop) begin
      if (count != CNT_ONE) data_d = mem_q[rd_nxt];
      else if (push)        data_d = tok_q;
    end else if (push && !valid) begin
      data_d = tok_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q  <= '0;
      slot_q <= '0;
      tok_q  <= '0;
      data_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
    end else begin
      ack_q  <= ack_d;
      slot_q <= slot_d;
      tok_q  <= tok_d;
      data_q <= data_d;
      if (push) wr_q <= wr_q + CNT_ONE;
      if (pop)  rd_q <= rd_q + CNT_ONE;
    end
  end

  // Storage needs no reset: it is only read behind the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= tok_q;
  end

  assign ra_a    = ack_q[0];
  assign ra_b    = ack_q[1];
  assign ra_c    = ack_q[2];
  assign ra_d    = ack_q[3];
  assign o_data  = data_q;
  assign o_valid = valid;
  assign o_count = count;

endmodule

// File: tb/tb_hs_collect_sync.sv
// tb_hs_collect_sync
//   Directed bench for hs_collect_sync (SYNC_STAGES=2, FIFO_DEPTH=4).
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_hs_collect_sync;

  logic       clk;
  logic       rst;
  logic       a, b, c, d;
  logic       rr_a, rr_b, rr_c, rr_d;
  logic       ra_a, ra_b, ra_c, ra_d;
  logic [3:0] o_data;
  logic       o_valid;
  logic       o_ready;
  logic [2:0] o_count;

  logic [3:0] ra_vec;
  assign ra_vec = {ra_d, ra_c, ra_b, ra_a};

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  hs_collect_sync #(.SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d),
    .rr_a(rr_a), .rr_b(rr_b), .rr_c(rr_c), .rr_d(rr_d),
    .ra_a(ra_a), .ra_b(ra_b), .ra_c(ra_c), .ra_d(ra_d),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_count(o_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Checking
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic set_rr(input logic [3:0] v);
    {rr_d, rr_c, rr_b, rr_a} = v;
  endtask

  task automatic set_data(input logic [3:0] v);
    {d, c, b, a} = v;
  endtask

  // Wait (bounded) on falling edges until the acknowledge vector matches.
  task automatic wait_ra(input logic [3:0] exp);
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      if (!done) begin
        @(negedge clk);
        if (ra_vec == exp) done = 1;
      end
    end
    if (!done) check_eq("ra_timeout", {28'd0, ra_vec}, {28'd0, exp});
  endtask

  // Full four-phase cycle on all four channels carrying word w.
  task automatic handshake(input logic [3:0] w);
    set_data(w);
    set_rr(4'hF);
    wait_ra(4'hF);
    set_rr(4'h0);
    wait_ra(4'h0);
    exp_q.push_back(w);
  endtask

  // Take one word from the output port and score it.
  task automatic pop_one();
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      check_eq("model_empty", 32'd1, 32'd0);
      e = 4'h0;
    end else begin
      e = exp_q.pop_front();
    end
    check_eq("pop_valid", {31'd0, o_valid}, 32'd1);
    check_eq("pop_data", {28'd0, o_data}, {28'd0, e});
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
  endtask

  logic [3:0] burst_w [8];

  initial begin
    burst_w[0] = 4'h1; burst_w[1] = 4'h2; burst_w[2] = 4'h4; burst_w[3] = 4'h8;
    burst_w[4] = 4'hF; burst_w[5] = 4'h0; burst_w[6] = 4'hB; burst_w[7] = 4'h6;

    // Reset with every request high
    rst = 1'b1;
    o_ready = 1'b0;
    set_data(4'h9);
    set_rr(4'hF);
    repeat (3) @(negedge clk);
    check_eq("rst_ra", {28'd0, ra_vec}, 32'd0);
    check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("rst_count", {29'd0, o_count}, 32'd0);
    check_eq("rst_data", {28'd0, o_data}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rel_ra_edge2", {28'd0, ra_vec}, 32'd0);
    @(negedge clk);
    check_eq("rel_ra_edge3", {28'd0, ra_vec}, 32'hF);
    check_eq("rel_count_edge3", {29'd0, o_count}, 32'd0);
    @(negedge clk);
    check_eq("rel_count_edge4", {29'd0, o_count}, 32'd1);
    check_eq("rel_data_edge4", {28'd0, o_data}, 32'h9);
    set_rr(4'h0);
    wait_ra(4'h0);
    exp_q.push_back(4'h9);
    pop_one();
    check_eq("rel_drained", {31'd0, o_valid}, 32'd0);

    // Single word a=1 b=0 c=1 d=1
    handshake(4'b1101);
    check_eq("single_count", {29'd0, o_count}, 32'd1);
    check_eq("single_data", {28'd0, o_data}, 32'hD);
    pop_one();
    check_eq("single_valid_after", {31'd0, o_valid}, 32'd0);
    check_eq("single_count_after", {29'd0, o_count}, 32'd0);
    check_eq("single_data_hold", {28'd0, o_data}, 32'hD);

    // Skewed arrival: channel a comes late
    set_data(4'b0110);
    set_rr(4'b1110);
    wait_ra(4'b1110);
    set_rr(4'b0000);
    wait_ra(4'b0000);
    repeat (12) @(negedge clk);
    check_eq("skew_no_push", {29'd0, o_count}, 32'd0);
    check_eq("skew_no_valid", {31'd0, o_valid}, 32'd0);
    a = 1'b0;
    rr_a = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("skew_ra_edge2", {28'd0, ra_vec}, 32'd0);
    @(negedge clk);
    check_eq("skew_ra_edge3", {28'd0, ra_vec}, 32'h1);
    check_eq("skew_count_edge3", {29'd0, o_count}, 32'd0);
    @(negedge clk);
    check_eq("skew_count_edge4", {29'd0, o_count}, 32'd1);
    check_eq("skew_data_edge4", {28'd0, o_data}, 32'h6);
    rr_a = 1'b0;
    wait_ra(4'h0);
    exp_q.push_back(4'h6);
    pop_one();
    check_eq("skew_drained", {31'd0, o_valid}, 32'd0);

    // Backpressure: four words fill the FIFO, the fifth sits in the slots
    handshake(4'h3);
    handshake(4'hA);
    handshake(4'h5);
    handshake(4'hC);
    handshake(4'h7);
    check_eq("bp_count_full", {29'd0, o_count}, 32'd4);
    check_eq("bp_head", {28'd0, o_data}, 32'h3);
    set_data(4'h9);
    set_rr(4'hF);
    repeat (8) @(negedge clk);
    check_eq("bp_stall_ra", {28'd0, ra_vec}, 32'd0);
    check_eq("bp_stall_count", {29'd0, o_count}, 32'd4);
    pop_one();
    check_eq("bp_pop_push_count", {29'd0, o_count}, 32'd4);
    check_eq("bp_next_head", {28'd0, o_data}, 32'hA);
    wait_ra(4'hF);
    set_rr(4'h0);
    wait_ra(4'h0);
    exp_q.push_back(4'h9);

    // Push and pop on the same edge while full, eight words
    for (int k = 0; k < 8; k++) begin
      pop_one();
      check_eq("full_pp_count", {29'd0, o_count}, 32'd4);
      handshake(burst_w[k]);
    end

    // Drain everything, FIFO plus the word still waiting in the slots
    o_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("drain_extra", 32'd1, 32'd0);
        end else begin
          check_eq("drain_data", {28'd0, o_data}, {28'd0, exp_q.pop_front()});
        end
      end
      @(negedge clk);
    end
    o_ready = 1'b0;
    check_eq("drain_left", exp_q.size(), 32'd0);
    check_eq("drain_count", {29'd0, o_count}, 32'd0);

    // Reset while ra_b is high and two words are buffered
    handshake(4'h5);
    handshake(4'hA);
    check_eq("mid_count_before", {29'd0, o_count}, 32'd2);
    b = 1'b1;
    rr_b = 1'b1;
    wait_ra(4'b0010);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_ra_async", {28'd0, ra_vec}, 32'd0);
    check_eq("mid_count_async", {29'd0, o_count}, 32'd0);
    check_eq("mid_valid_async", {31'd0, o_valid}, 32'd0);
    exp_q.delete();
    rr_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    handshake(4'h7);
    handshake(4'hE);
    check_eq("post_rst_count", {29'd0, o_count}, 32'd2);
    pop_one();
    pop_one();
    check_eq("post_rst_empty", {31'd0, o_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
